// File: rtl/secuenciador_melodia.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_melodia
// Purpose  : Steps an external note table and drives a square-wave buzzer per
//            note, each followed by a silent articulation gap.
//            Optional macro TEMPO_AJUSTE_EN adds a tempo[1:0] speed port.
// Revision : 1.0  initial release
// ============================================================================
module secuenciador_melodia #(
    parameter int CLOCK_FREQUENCY = 12000000,
    parameter int HALF_W          = 16,
    parameter int IDX_W           = 5,
    parameter int NUM_NOTAS       = 30,
    parameter int BEAT_TICKS      = CLOCK_FREQUENCY / 8,
    parameter int GAP_TICKS       = CLOCK_FREQUENCY / 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
`ifdef TEMPO_AJUSTE_EN
    input  logic [1:0]        tempo,
`endif
    input  logic [HALF_W-1:0] semiperiodo,
    input  logic [2:0]        duracion,
    output logic [IDX_W-1:0]  idx,
    output logic              buzzer,
    output logic              busy,
    output logic              fin
);

    localparam int CNT_W = $clog2(7 * BEAT_TICKS + 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_TONE = 3'd2;
    localparam logic [2:0] c_GAP  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_NOTAS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD = CNT_W'(GAP_TICKS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
    logic              r_buzzer, w_buzzer_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_fin,    w_fin_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [HALF_W-1:0] r_half,   w_half_nxt;
    logic [HALF_W-1:0] r_hcnt,   w_hcnt_nxt;

    logic [2:0]        w_dur;
    logic [CNT_W-1:0]  w_unit;
    logic [CNT_W-1:0]  w_tone_load;
    logic              w_sentinel;
    logic              w_cnt_last;

    assign w_dur      = (duracion == 3'd0) ? 3'd1 : duracion;
`ifdef TEMPO_AJUSTE_EN
    assign w_unit     = CNT_W'(BEAT_TICKS) >> tempo;
`else
    assign w_unit     = CNT_W'(BEAT_TICKS);
`endif
    // The gap is carved out of the note so that LOAD + tone + gap = 1 + d*unit.
    assign w_tone_load = (CNT_W'(w_dur) * w_unit) - c_GAP_LOAD;
    assign w_sentinel  = (semiperiodo == '0);
    assign w_cnt_last  = (r_cnt == c_CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: if (start) w_state_nxt = c_LOAD;
                c_LOAD: begin
                    if (w_sentinel) w_state_nxt = loop ? c_LOAD : c_DONE;
                    else            w_state_nxt = c_TONE;
                end
                c_TONE: if (w_cnt_last) w_state_nxt = c_GAP;
                c_GAP: begin
                    if (w_cnt_last) begin
                        if (r_idx == c_LAST_IDX && !loop) w_state_nxt = c_DONE;
                        else                              w_state_nxt = c_LOAD;
                    end
                end
                c_DONE:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_idx_nxt    = r_idx;
        w_buzzer_nxt = r_buzzer;
        w_cnt_nxt    = r_cnt;
        w_half_nxt   = r_half;
        w_hcnt_nxt   = r_hcnt;
        if (stop) begin
            w_idx_nxt    = '0;
            w_buzzer_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_hcnt_nxt   = '0;
        end else begin
            case (r_state)
                c_IDLE: if (start) w_idx_nxt = '0;
                c_LOAD: begin
                    w_half_nxt = semiperiodo;
                    if (w_sentinel) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_cnt_nxt    = w_tone_load;
                        w_hcnt_nxt   = '0;
                        w_buzzer_nxt = 1'b0;
                    end
                end
                c_TONE: begin
                    if (w_cnt_last) begin
                        w_buzzer_nxt = 1'b0;
                        w_cnt_nxt    = c_GAP_LOAD;
                        w_hcnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                        if (r_hcnt == r_half - HALF_W'(1)) begin
                            w_hcnt_nxt   = '0;
                            w_buzzer_nxt = ~r_buzzer;
                        end else begin
                            w_hcnt_nxt = r_hcnt + HALF_W'(1);
                        end
                    end
                end
                c_GAP: begin
                    w_buzzer_nxt = 1'b0;
                    if (w_cnt_last) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = (r_idx == c_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
                c_DONE:  w_idx_nxt = '0;
                default: w_idx_nxt = '0;
            endcase
        end
        w_busy_nxt = (w_state_nxt == c_LOAD) || (w_state_nxt == c_TONE) ||
                     (w_state_nxt == c_GAP);
        w_fin_nxt  = (w_state_nxt == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_buzzer <= 1'b0;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
            r_cnt    <= '0;
            r_half   <= '0;
            r_hcnt   <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_buzzer <= w_buzzer_nxt;
            r_busy   <= w_busy_nxt;
            r_fin    <= w_fin_nxt;
            r_cnt    <= w_cnt_nxt;
            r_half   <= w_half_nxt;
            r_hcnt   <= w_hcnt_nxt;
        end
    end

    assign idx    = r_idx;
    assign buzzer = r_buzzer;
    assign busy   = r_busy;
    assign fin    = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_melodia.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_melodia
// Purpose  : Directed self-checking bench for secuenciador_melodia using a
//            four-entry note table {5,1} {3,2} {7,1} {0,x}.
// Revision : 1.0  initial release
// ============================================================================
module tb_secuenciador_melodia;

    localparam int HALF_W    = 16;
    localparam int IDX_W     = 5;
    localparam int NUM_NOTAS = 4;
    localparam int BEAT      = 100;
    localparam int GAP       = 10;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic              loop  = 1'b0;
`ifdef TEMPO_AJUSTE_EN
    logic [1:0]        tempo = 2'd0;
`endif
    logic [HALF_W-1:0] semiperiodo;
    logic [2:0]        duracion;
    logic [2:0]        dur0  = 3'd1;
    logic [IDX_W-1:0]  idx;
    logic              buzzer;
    logic              busy;
    logic              fin;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always_comb begin
        semiperiodo = '0;
        duracion    = 3'd0;
        case (idx)
            5'd0: begin semiperiodo = 16'd5; duracion = dur0; end
            5'd1: begin semiperiodo = 16'd3; duracion = 3'd2; end
            5'd2: begin semiperiodo = 16'd7; duracion = 3'd1; end
            default: begin semiperiodo = '0; duracion = 3'd5; end
        endcase
    end

    secuenciador_melodia #(
        .CLOCK_FREQUENCY(12000000),
        .HALF_W         (HALF_W),
        .IDX_W          (IDX_W),
        .NUM_NOTAS      (NUM_NOTAS),
        .BEAT_TICKS     (BEAT),
        .GAP_TICKS      (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
`ifdef TEMPO_AJUSTE_EN
        .tempo      (tempo),
`endif
        .semiperiodo(semiperiodo),
        .duracion   (duracion),
        .idx        (idx),
        .buzzer     (buzzer),
        .busy       (busy),
        .fin        (fin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Called at a falling edge; start is sampled on the next rising edge (cycle 0).
    task automatic start_play();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        logic exp_buz;

        repeat (3) @(negedge clk);
        check("rst_idx", 32'(idx), 0);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fin", 32'(fin), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a tone
        start_play();
        go_to(10);
        check("s1_busy_pre", 32'(busy), 1);
        check("s1_buz_pre", 32'(buzzer), 1);
        #1 rst_n = 1'b0;
        #1;
        check("s1_async_idx", 32'(idx), 0);
        check("s1_async_buzzer", 32'(buzzer), 0);
        check("s1_async_busy", 32'(busy), 0);
        check("s1_async_fin", 32'(fin), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("s1_post_busy", 32'(busy), 0);
        check("s1_post_idx", 32'(idx), 0);

        // Full run, no loop
        loop = 1'b0;
        start_play();
        check("s2_busy_c1", 32'(busy), 1);
        check("s2_idx_c1", 32'(idx), 0);
        check("s2_buz_c1", 32'(buzzer), 0);
        for (int c = 2; c <= 101; c++) begin
            go_to(c);
            exp_buz = (c <= 91) && ((((c - 2) / 5) % 2) == 1);
            check("s2_buz_wave", 32'(buzzer), 32'(exp_buz));
        end
        check("s2_idx_c101", 32'(idx), 0);
        go_to(102);
        check("s2_idx_c102", 32'(idx), 1);
        go_to(105);
        check("s3_n1_buz_c105", 32'(buzzer), 0);
        go_to(106);
        check("s3_n1_buz_c106", 32'(buzzer), 1);
        go_to(302);
        check("s3_idx_c302", 32'(idx), 1);
        go_to(303);
        check("s3_idx_c303", 32'(idx), 2);
        go_to(404);
        check("s3_idx_c404", 32'(idx), 3);
        check("s3_busy_c404", 32'(busy), 1);
        check("s3_fin_c404", 32'(fin), 0);
        go_to(405);
        check("s3_fin_c405", 32'(fin), 1);
        check("s3_busy_c405", 32'(busy), 0);
        check("s3_idx_c405", 32'(idx), 0);
        go_to(406);
        check("s3_fin_c406", 32'(fin), 0);
        check("s3_busy_c406", 32'(busy), 0);

        // Looping run, then stop mid-tone
        loop = 1'b1;
        start_play();
        go_to(404);
        check("s4_idx_c404", 32'(idx), 3);
        go_to(405);
        check("s4_idx_c405", 32'(idx), 0);
        check("s4_busy_c405", 32'(busy), 1);
        check("s4_fin_c405", 32'(fin), 0);
        go_to(411);
        check("s4_buz_c411", 32'(buzzer), 1);
        go_to(420);
        check("s4_busy_c420", 32'(busy), 1);
        stop = 1'b1;
        go_to(421);
        stop = 1'b0;
        loop = 1'b0;
        check("s4_stop_busy", 32'(busy), 0);
        check("s4_stop_buzzer", 32'(buzzer), 0);
        check("s4_stop_idx", 32'(idx), 0);
        check("s4_stop_fin", 32'(fin), 0);
        go_to(425);
        check("s4_idle_busy", 32'(busy), 0);
        check("s4_idle_fin", 32'(fin), 0);

        // stop together with start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        go_to(426);
        start = 1'b0;
        stop  = 1'b0;
        go_to(427);
        check("s4_stopstart_busy", 32'(busy), 0);

        // duracion=0 acts as 1; start while busy is ignored
        dur0 = 3'd0;
        start_play();
        go_to(50);
        start = 1'b1;
        go_to(51);
        start = 1'b0;
        go_to(91);
        check("s5_buz_c91", 32'(buzzer), 1);
        check("s5_busy_c91", 32'(busy), 1);
        go_to(92);
        check("s5_buz_c92", 32'(buzzer), 0);
        go_to(101);
        check("s5_idx_c101", 32'(idx), 0);
        go_to(102);
        check("s5_idx_c102", 32'(idx), 1);
        stop = 1'b1;
        go_to(103);
        stop = 1'b0;
        dur0 = 3'd1;
        check("s5_stop_busy", 32'(busy), 0);

`ifdef TEMPO_AJUSTE_EN
        // Double speed: 40-cycle tone, 10-cycle gap
        tempo = 2'd1;
        start_play();
        go_to(41);
        check("s6_buz_c41", 32'(buzzer), 1);
        check("s6_busy_c41", 32'(busy), 1);
        go_to(42);
        check("s6_buz_c42", 32'(buzzer), 0);
        go_to(51);
        check("s6_idx_c51", 32'(idx), 0);
        go_to(52);
        check("s6_idx_c52", 32'(idx), 1);
        stop = 1'b1;
        go_to(53);
        stop  = 1'b0;
        tempo = 2'd0;
        check("s6_stop_busy", 32'(busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
